// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from an upstream synchronous FIFO and sends 8N1-style frames.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_empty,
    output logic             o_rreq,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             rreq_q, rreq_d;
    logic             bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rreq_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rreq_q  <= rreq_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Counters restart from 0 on every state change; untimed states hold them at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!i_empty) state_d = S_REQ;
            end
            S_REQ: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d   = '0;
                shift_d = i_data;
`ifdef FIFO_UART_TX_PARITY_EN
                par_d   = ^i_data;
`endif
                state_d = S_START;
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered line tracks the state with no lag.
    always_comb begin
        rreq_d = (state_d == S_REQ);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign o_tx   = tx_q;
    assign o_rreq = rreq_q;
    assign o_busy = (state_q != S_IDLE);
    assign o_done = (state_q == S_STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomized bench for fifo_uart_tx: a FIFO model feeds words, a line monitor captures frames,
// and expected frames are built from the serial frame format directly.
module tb_fifo_uart_tx;

    localparam int W   = 8;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = W + 3;
`else
    localparam int NB = W + 2;
`endif
    localparam int FL = NB * CPB;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] i_data;
    logic         i_empty;
    logic         o_rreq, o_tx, o_busy, o_done;

    int n_chk = 0;
    int n_err = 0;

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_empty(i_empty),
        .o_rreq(o_rreq), .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    // FIFO model: word appears on i_data the cycle after the read request
    logic [W-1:0] fmem [64];
    int wp = 0;
    int rp = 0;
    assign i_empty = (wp == rp);

    initial i_data = '0;
    always @(posedge clk) begin
        if (reset_n && o_rreq && wp != rp) begin
            i_data <= fmem[rp % 64];
            rp     <= rp + 1;
        end
    end

    // Line monitor: capture each frame's line and done samples, cycle by cycle.
    logic [63:0] obs_a [64];
    logic [63:0] dn_a  [64];
    int          st_a  [64];
    int          nfr = 0, fc = 0, cyc = 0;
    int          rreq_cnt = 0, rreq_dbl = 0, done_cnt = 0;
    bit          in_frame = 0, prev_rreq = 0;
    logic [63:0] obs, dob;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            in_frame  = 0;
            prev_rreq = 0;
        end else begin
            if (o_rreq) begin
                rreq_cnt++;
                if (prev_rreq) rreq_dbl++;
            end
            prev_rreq = o_rreq;
            if (o_done) done_cnt++;
            if (!in_frame && o_tx == 1'b0) begin
                in_frame = 1;
                fc = 0;
                obs = '0;
                dob = '0;
                st_a[nfr % 64] = cyc;
            end
            if (in_frame) begin
                obs[fc] = o_tx;
                dob[fc] = o_done;
                fc++;
                if (fc == FL) begin
                    obs_a[nfr % 64] = obs;
                    dn_a[nfr % 64]  = dob;
                    nfr++;
                    in_frame = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame as bit slots: start 0, data LSB first, optional even parity, stop 1.
    function automatic logic [63:0] exp_frame(input logic [W-1:0] w);
        logic [63:0] f;
        int s;
        f = '0;
        for (int c = 0; c < FL; c++) begin
            s = c / CPB;
            if (s == 0)       f[c] = 1'b0;
            else if (s <= W)  f[c] = w[s-1];
            else if (s == W + 1 && NB == W + 3) f[c] = ^w;
            else              f[c] = 1'b1;
        end
        return f;
    endfunction

    logic [W-1:0] exp_q [$];
    int rd_fr = 0;

    task automatic push(input logic [W-1:0] w, input bit completes);
        fmem[wp % 64] = w;
        wp = wp + 1;
        if (completes) exp_q.push_back(w);
    endtask

    task automatic drain(input int n, input bit gapchk);
        logic [W-1:0] w;
        for (int i = 0; i < n * (FL + 80) + 200 && nfr < rd_fr + n; i++) @(negedge clk);
        chk("frames_seen", 64'(nfr - rd_fr), 64'(n));
        for (int k = 0; k < n && rd_fr < nfr && exp_q.size() > 0; k++) begin
            w = exp_q.pop_front();
            chk("frame_bits", obs_a[rd_fr % 64], exp_frame(w));
            chk("done_pos", dn_a[rd_fr % 64], 64'(1) << (FL - 1));
            if (gapchk && k > 0)
                chk("hi_gap", 64'(st_a[rd_fr % 64] - st_a[(rd_fr - 1) % 64] - (FL - CPB)), 64'(CPB + 3));
            rd_fr++;
        end
    endtask

    int bad, d0;

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 64'(o_tx), 64'd1);
        chk("rst_rreq", 64'(o_rreq), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        reset_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_rreq || !o_tx || o_busy) bad++;
        end
        chk("empty_idle", 64'(bad), 64'd0);

        push(8'hA5, 1);
        drain(1, 0);
        chk("a5_rreq", 64'(rreq_cnt), 64'd1);

        push(8'h03, 1);
        push(8'h04, 1);
        push(8'h05, 1);
        drain(3, 1);
        chk("b2b_rreq", 64'(rreq_cnt), 64'd4);
        chk("b2b_empty", 64'(i_empty), 64'd1);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 60)) @(negedge clk);
            push(W'($urandom), 1);
        end
        drain(20, 0);

        // Abort a frame mid-DATA; the word is lost and no done may follow.
        push(8'h5A, 0);
        for (int i = 0; i < 500 && !(in_frame && fc >= 3 * CPB); i++) @(negedge clk);
        chk("abort_in_data", 64'(in_frame && fc >= 3 * CPB), 64'd1);
        d0 = done_cnt;
        #1 reset_n = 1'b0;
        #1;
        chk("arst_tx", 64'(o_tx), 64'd1);
        chk("arst_rreq", 64'(o_rreq), 64'd0);
        chk("arst_busy", 64'(o_busy), 64'd0);
        chk("arst_done", 64'(o_done), 64'd0);
        @(negedge clk);
        push(8'h3C, 1);
        repeat (2) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(d0));
        reset_n = 1'b1;
        @(negedge clk);
        chk("recov_rreq", 64'(o_rreq), 64'd1);
        drain(1, 0);
        chk("recov_done", 64'(done_cnt), 64'(d0 + 1));

        repeat (20) @(negedge clk);
        chk("rreq_total", 64'(rreq_cnt), 64'(wp));
        chk("rreq_width", 64'(rreq_dbl), 64'd0);
        chk("done_total", 64'(done_cnt), 64'(nfr));
        chk("fifo_drained", 64'(wp - rp), 64'd0);
        chk("line_idle", 64'(o_tx), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits; matches the sFIFO data width.
REQ-002 Parameter CLKS_PER_BIT, default 4: clk cycles per serial bit time; legal values are 1 or more.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1: asynchronous, active-low reset.
REQ-005 i_data  input  WIDTH: read data from the upstream FIFO (its Data_out).
REQ-006 i_empty  input  1: FIFO empty flag (its fifoisempty); 1 means no word is available.
REQ-007 o_rreq  output  1: FIFO read request (drives its i_rreq); registered output.
REQ-008 o_tx  output  1: serial line; idles high; registered output.
REQ-009 o_busy  output  1: high whenever the state is not IDLE.
REQ-010 o_done  output  1: one-cycle pulse marking frame completion.

Function
REQ-011 The block SHALL implement states IDLE, REQ, WAIT, START, DATA, PARITY (macro-dependent), and STOP.
REQ-012 IDLE: o_tx=1 and o_rreq=0; when i_empty=0 is sampled, the next state SHALL be REQ, otherwise the block SHALL remain in IDLE.
REQ-013 REQ: o_rreq=1 for exactly one cycle, then the state SHALL go to WAIT unconditionally.
REQ-014 WAIT: lasts one cycle; the FIFO presents the read word during it; i_data SHALL be latched into the shift register at the end of WAIT, then the state SHALL go to START.
REQ-015 START: o_tx=0 for CLKS_PER_BIT cycles.
REQ-016 DATA: WIDTH bits SHALL be sent LSB first, each held for CLKS_PER_BIT cycles; the shift register SHALL shift right once per bit time.
REQ-017 STOP: o_tx=1 for CLKS_PER_BIT cycles; o_done=1 on the last STOP cycle only; the next state SHALL be IDLE.
REQ-018 Line timing: o_tx SHALL go low at the 2nd rising edge after the edge that samples i_empty=0 in IDLE.
REQ-019 Back-to-back frames: the line SHALL stay high for exactly CLKS_PER_BIT+3 cycles between frames (STOP, then IDLE, REQ, and WAIT).
REQ-020 Frame length SHALL be (WIDTH+2)*CLKS_PER_BIT cycles without parity and (WIDTH+3)*CLKS_PER_BIT with parity.
REQ-021 Exactly one o_rreq pulse SHALL occur per frame; o_rreq SHALL never assert outside REQ.
REQ-022 i_empty and i_data SHALL be ignored outside IDLE and WAIT respectively.
REQ-023 The bit-time counter width SHALL be clog2(CLKS_PER_BIT)+1 bits; the bit-index counter width SHALL be clog2(WIDTH)+1 bits; both SHALL reset to 0 at each state entry.

Reset
REQ-024 reset_n=0 SHALL force, immediately and asynchronously, state=IDLE, o_tx=1, o_rreq=0, o_busy=0, o_done=0, and shift register and counters to 0.
REQ-025 Reset mid-frame SHALL abort the frame with no o_done pulse; the aborted word is lost.
REQ-026 After reset_n rises, the block SHALL resume normal IDLE behaviour on the next sampling edge.

Configuration
REQ-027 Macro FIFO_UART_TX_PARITY_EN defined: a PARITY state SHALL be inserted between DATA and STOP, driving the even-parity bit (XOR of the latched word) for CLKS_PER_BIT cycles.
REQ-028 Macro FIFO_UART_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Verification
REQ-029 Reset: hold reset_n=0 mid-DATA -> o_tx=1, o_rreq=0, o_busy=0, o_done=0 within the same cycle; no o_done afterwards.
REQ-030 Single word: FIFO holds 0xA5 (WIDTH=8, CLKS_PER_BIT=4) -> one o_rreq pulse; line reads 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; 40-cycle frame; one o_done pulse.
REQ-031 Back-to-back: FIFO holds 0x03, 0x04, 0x05 -> three o_rreq pulses; frames carry 0x03, 0x04, 0x05 in order; the high gap between the start bits of consecutive frames is 7 cycles; the FIFO ends empty.
REQ-032 Empty: i_empty=1 for 200 cycles -> o_rreq never asserts; o_tx stays 1; o_busy stays 0.
REQ-033 Recovery: after the reset abort with i_empty=0 -> a fresh o_rreq pulse occurs 1 cycle after reset release is sampled, and a complete frame follows.
REQ-034 Parity (macro defined): words 0x07 and 0x03 -> parity bits 1 and 0; 44-cycle frames.
